// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
//   op_e       : operation select (OP_ADD / OP_SUB), matches the 'sub' input encoding
//   num_chunks : number of CHUNK-bit ripple segments (= pipeline stages) for a width
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry segment built from full_adder cells.
//   a, b : segment operands
//   cin  : carry into bit 0
//   sum  : segment sum
//   cout : carry out of the segment MSB
//   cmsb : carry into the segment MSB (used for signed overflow on the top segment)
module adder_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  // Each bit keeps its own carry nets so the chain is not one self-dependent vector.
  for (genvar i = 0; i < CHUNK; i++) begin : gen_bit
    logic ci_w;
    logic co_w;
    if (i == 0) begin : gen_lsb
      assign ci_w = cin;
    end else begin : gen_mid
      assign ci_w = gen_bit[i-1].co_w;
    end
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (ci_w),
      .s  (sum[i]),
      .co (co_w)
    );
  end

  assign cout = gen_bit[CHUNK-1].co_w;
  assign cmsb = gen_bit[CHUNK-1].ci_w;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit two's-complement adder/subtractor, one CHUNK-bit ripple
// segment per stage, latency STAGES = WIDTH/CHUNK, one op per cycle, global stall.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : upstream handshake (in_ready combinational from out_ready)
//   a, b, cin, sub       : operands, carry/borrow-in, 0 = a+b+cin, 1 = a-b-cin
//   out_valid / out_ready: downstream handshake
//   sum, cout, ovf       : result mod 2^WIDTH, carry out of MSB, signed overflow
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = num_chunks(WIDTH, CHUNK);

  if (CHUNK == 0 || WIDTH % CHUNK != 0) begin : gen_chunk_check
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Operands travel with the op; opb is already inverted for subtraction.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             cmsb;
  } stage_t;

  stage_t stage_in [STAGES];
  stage_t stage_d  [STAGES];
  stage_t stage_q  [STAGES];

  op_e  op;
  logic en;

  assign op       = op_e'(sub);
  assign en       = !out_valid || out_ready;
  assign in_ready = en || rst;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    logic [CHUNK-1:0] csum;
    logic             ccout;
    logic             ccmsb;
    logic [WIDTH-1:0] sum_m;

    if (k == 0) begin : gen_first
      // a - b - cin == a + ~b + (1 - cin)
      assign stage_in[k] = '{
        vld:   in_valid,
        opa:   a,
        opb:   (op == OP_SUB) ? ~b : b,
        sum:   '0,
        carry: (op == OP_SUB) ? ~cin : cin,
        cmsb:  1'b0
      };
    end else begin : gen_next
      assign stage_in[k] = stage_q[k-1];
    end

    adder_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a    (stage_in[k].opa[k*CHUNK +: CHUNK]),
      .b    (stage_in[k].opb[k*CHUNK +: CHUNK]),
      .cin  (stage_in[k].carry),
      .sum  (csum),
      .cout (ccout),
      .cmsb (ccmsb)
    );

    always_comb begin
      sum_m                      = stage_in[k].sum;
      sum_m[k*CHUNK +: CHUNK]    = csum;
    end

    assign stage_d[k] = '{
      vld:   stage_in[k].vld,
      opa:   stage_in[k].opa,
      opb:   stage_in[k].opb,
      sum:   sum_m,
      carry: ccout,
      cmsb:  ccmsb
    };
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = stage_q[STAGES-1].vld;
  assign sum       = stage_q[STAGES-1].sum;
  assign cout      = stage_q[STAGES-1].carry;
  assign ovf       = stage_q[STAGES-1].carry ^ stage_q[STAGES-1].cmsb;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three instances (CHUNK 4, 8, 32) at WIDTH 32.
// Directed tests run on the CHUNK=8 instance; random traffic runs on all three.
module tb_pipelined_addsub;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic         cins [3];
  logic         subs [3];
  logic         co   [3];
  logic         of   [3];
  logic [W-1:0] ia   [3];
  logic [W-1:0] ib   [3];
  logic [W-1:0] sm   [3];

  pipelined_addsub #(.WIDTH(W), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(ia[0]), .b(ib[0]),
    .cin(cins[0]), .sub(subs[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]),
    .cout(co[0]), .ovf(of[0])
  );
  pipelined_addsub #(.WIDTH(W), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(ia[1]), .b(ib[1]),
    .cin(cins[1]), .sub(subs[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]),
    .cout(co[1]), .ovf(of[1])
  );
  pipelined_addsub #(.WIDTH(W), .CHUNK(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(ia[2]), .b(ib[2]),
    .cin(cins[2]), .sub(subs[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]),
    .cout(co[2]), .ovf(of[2])
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  int ncmp  = 0;
  int nfail = 0;

  // Expected results per instance, circular buffer (in flight never exceeds 8).
  res_t expm [3][64];
  int   wp   [3];
  int   rp   [3];

  // Golden model: exact integer arithmetic, then reduce to the WIDTH-bit view.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t   r;
    longint ua, ub, sa, sb, ur, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!sub) begin
      ur = ua + ub + longint'(cin);
      sr = sa + sb + longint'(cin);
      r.cout = (ur >= 64'sh1_0000_0000);
    end else begin
      ur = ua - ub - longint'(cin);
      sr = sa - sb - longint'(cin);
      r.cout = (ur >= 0);
    end
    r.sum = ur[W-1:0];
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic chk_res(input string nm, input int d, input res_t e);
    ncmp++;
    if (sm[d] !== e.sum || co[d] !== e.cout || of[d] !== e.ovf) begin
      nfail++;
      $display("FAIL %s (dut%0d): got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
               nm, d, sm[d], co[d], of[d], e.sum, e.cout, e.ovf);
    end
  endtask

  task automatic chk_val(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
      ia[d]   = '0;
      ib[d]   = '0;
      cins[d] = 1'b0;
      subs[d] = 1'b0;
    end
  endtask

  // Single op on the CHUNK=8 instance, measuring edges from acceptance to out_valid.
  task automatic send_one(input string nm, input vec_t v);
    int   lat;
    res_t e;
    @(posedge clk); #1;
    ia[1] = v.a; ib[1] = v.b; cins[1] = v.cin; subs[1] = v.sub;
    iv[1] = 1'b1; ordy[1] = 1'b1;
    @(negedge clk);
    chk_val({nm, " in_ready"}, 64'(ir[1]), 64'd1);
    @(posedge clk); #1;
    iv[1] = 1'b0;
    lat = 1;
    while (!ov[1] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_val({nm, " latency"}, 64'(lat), 64'd4);
    e.sum = v.esum; e.cout = v.ecout; e.ovf = v.eovf;
    chk_res(nm, 1, e);
  endtask

  vec_t tbl [10];

  initial begin
    for (int d = 0; d < 3; d++) begin
      wp[d] = 0;
      rp[d] = 0;
    end
    tbl[0] = '{32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'h5,         32'h7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[4] = '{32'h1,         32'h2,         1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
    tbl[5] = '{32'hA,         32'h3,         1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
    tbl[6] = '{32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[7] = '{32'h0,         32'h0,         1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[8] = '{32'h0000_00FF, 32'h1,         1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    // Reset and reset state.
    idle_all();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_val("in_ready during reset", 64'(ir[1]), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      res_t z;
      z.sum = '0; z.cout = 1'b0; z.ovf = 1'b0;
      chk_res("reset outputs", d, z);
      chk_val($sformatf("reset out_valid dut%0d", d), 64'(ov[d]), 64'd0);
    end

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      send_one($sformatf("vec%0d", i), tbl[i]);
    end

    // Back-to-back stream with a 3-cycle downstream stall.
    begin
      logic [W-1:0] a4   [6];
      logic [W-1:0] b4   [6];
      res_t         exp4 [6];
      logic [63:0]  held;
      logic         hold_v;
      int           idx, got;
      for (int i = 0; i < 6; i++) begin
        a4[i]   = 32'h1111_1111 * (i + 1) + 32'hFF;
        b4[i]   = 32'h0F0F_0F0F + i;
        exp4[i] = model(a4[i], b4[i], 1'(i), 1'(i >> 1));
      end
      @(posedge clk);
      idx = 0; got = 0; hold_v = 1'b0; held = '0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
        @(posedge clk); #1;
        ordy[1] = !(cyc >= 4 && cyc <= 6);
        if (idx < 6) begin
          iv[1] = 1'b1; ia[1] = a4[idx]; ib[1] = b4[idx];
          cins[1] = 1'(idx); subs[1] = 1'(idx >> 1);
        end else begin
          iv[1] = 1'b0;
        end
        @(negedge clk);
        if (ov[1] && !ordy[1]) begin
          chk_val("stall in_ready", 64'(ir[1]), 64'd0);
          if (hold_v) chk_val("stall hold", {30'd0, co[1], of[1], sm[1]}, held);
          held   = {30'd0, co[1], of[1], sm[1]};
          hold_v = 1'b1;
        end else begin
          hold_v = 1'b0;
        end
        if (iv[1] && ir[1]) idx++;
        if (ov[1] && ordy[1]) begin
          chk_res($sformatf("stream op%0d", got), 1, exp4[got]);
          got++;
        end
      end
      chk_val("stream accepted", 64'(idx), 64'd6);
      chk_val("stream emitted", 64'(got), 64'd6);
      iv[1] = 1'b0;
      ordy[1] = 1'b1;
    end

    // Reset flush with ops in flight.
    begin
      int seen;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        iv[1] = 1'b1; ia[1] = 32'h100 + i; ib[1] = 32'h7; cins[1] = 1'b0; subs[1] = 1'b0;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      ia[1] = 32'hDEAD_BEEF;  // must be ignored while in reset
      @(negedge clk);
      chk_val("flush in_ready during reset", 64'(ir[1]), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      iv[1] = 1'b0;
      chk_val("flush out_valid after reset", 64'(ov[1]), 64'd0);
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (ov[1]) seen++;
      end
      chk_val("flush nothing emitted", 64'(seen), 64'd0);
      send_one("post-flush", tbl[1]);
    end

    // Random traffic on all three instances against the model.
    idle_all();
    @(posedge clk);
    for (int cyc = 0; cyc < 15000 + 40; cyc++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (cyc < 15000) begin
          iv[d]   = ($urandom_range(3) != 0);
          ordy[d] = ($urandom_range(3) != 0);
          ia[d]   = rnd_op();
          ib[d]   = rnd_op();
          cins[d] = 1'($urandom_range(1));
          subs[d] = 1'($urandom_range(1));
        end else begin
          iv[d]   = 1'b0;
          ordy[d] = 1'b1;
        end
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && ordy[d]) begin
          if (rp[d] == wp[d]) begin
            chk_val($sformatf("spurious out_valid dut%0d", d), 64'(ov[d]), 64'd0);
          end else begin
            chk_res("random", d, expm[d][rp[d] % 64]);
            rp[d]++;
          end
        end
        if (iv[d] && ir[d]) begin
          expm[d][wp[d] % 64] = model(ia[d], ib[d], cins[d], subs[d]);
          wp[d]++;
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      chk_val($sformatf("drained dut%0d", d), 64'(wp[d] - rp[d]), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
